// File: rtl/lzc_pkg.sv
// ---------------------------------------------------------------------------
// lzc_pkg
// Shared definitions for the leading-zero counter:
//   LZC_CNT_W        - width of the count output (fits 0..64)
//   LZC_ARCH_*       - architecture selector encodings
//   clog2()          - ceiling log2, usable at elaboration time
// ---------------------------------------------------------------------------
package lzc_pkg;

  localparam int LZC_CNT_W       = 7;

  localparam int LZC_ARCH_SCAN   = 0;
  localparam int LZC_ARCH_TREE   = 1;
  localparam int LZC_ARCH_NIBBLE = 2;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/lzc_core.sv
// ---------------------------------------------------------------------------
// lzc_core
// Purely combinational leading-zero count of a WIDTH-bit unsigned word.
// Three bit-exact architectures selected by ARCH (see lzc_pkg encodings).
// Ports:
//   data_i [WIDTH-1:0]     word to count
//   cnt_o  [LZC_CNT_W-1:0] zeros above the highest set bit (WIDTH if none)
//   zero_o                 data_i is all zeros
// ---------------------------------------------------------------------------
module lzc_core
  import lzc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ARCH  = 1
) (
  input  logic [WIDTH-1:0]     data_i,
  output logic [LZC_CNT_W-1:0] cnt_o,
  output logic                 zero_o
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("lzc_core: WIDTH=%0d outside legal range 1..64", WIDTH);
  end

  // Zero detection looks only at the real input bits, never at padding.
  assign zero_o = ~|data_i;

  if (ARCH == LZC_ARCH_SCAN) begin : g_scan
    logic [LZC_CNT_W-1:0] scan_cnt;
    // Scan upward so the last hit is the most significant set bit.
    always_comb begin
      scan_cnt = LZC_CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
        if (data_i[i]) scan_cnt = LZC_CNT_W'(WIDTH - 1 - i);
      end
    end
    assign cnt_o = scan_cnt;

  end else if (ARCH == LZC_ARCH_TREE) begin : g_tree
    localparam int L = clog2(WIDTH);
    localparam int P = 1 << L;

    if (P == 1) begin : g_single
      assign cnt_o = data_i[0] ? LZC_CNT_W'(0) : LZC_CNT_W'(1);
    end else begin : g_multi
      logic [P-1:0] padded;
      // Ones below the LSB keep every non-zero input's count unchanged.
      if (P > WIDTH) begin : g_pad
        assign padded = {data_i, {(P - WIDTH){1'b1}}};
      end else begin : g_nopad
        assign padded = data_i;
      end

      // Node n of level gl covers padded bits [(n+1)*2^gl-1 : n*2^gl];
      // child 2n+1 is the more significant (left) half.
      for (genvar gl = 0; gl <= L; gl++) begin : g_lvl
        localparam int N = P >> gl;
        logic [N-1:0] v;
        logic [L-1:0] c [N];
        if (gl == 0) begin : g_leaf
          assign v = padded;
          for (genvar gn = 0; gn < N; gn++) begin : g_node
            assign c[gn] = '0;
          end
        end else begin : g_merge
          for (genvar gn = 0; gn < N; gn++) begin : g_node
            assign v[gn] = g_lvl[gl-1].v[2*gn+1] | g_lvl[gl-1].v[2*gn];
            // Left half non-zero: its count; else 2^(gl-1) + right count.
            assign c[gn] = g_lvl[gl-1].v[2*gn+1]
                         ? g_lvl[gl-1].c[2*gn+1]
                         : (g_lvl[gl-1].c[2*gn] | L'(1 << (gl - 1)));
          end
        end
      end

      assign cnt_o = (zero_o || !g_lvl[L].v[0]) ? LZC_CNT_W'(WIDTH)
                                                : LZC_CNT_W'(g_lvl[L].c[0]);
    end

  end else if (ARCH == LZC_ARCH_NIBBLE) begin : g_nibble
    localparam int Q = ((WIDTH + 3) / 4) * 4;
    localparam int G = Q / 4;

    logic [Q-1:0]         padded;
    logic [LZC_CNT_W-1:0] grp_cnt;

    if (Q > WIDTH) begin : g_pad
      assign padded = {data_i, {(Q - WIDTH){1'b1}}};
    end else begin : g_nopad
      assign padded = data_i;
    end

    // Leading zeros within a non-zero nibble.
    function automatic logic [1:0] nib_lz(input logic [3:0] x);
      casez (x)
        4'b1???: nib_lz = 2'd0;
        4'b01??: nib_lz = 2'd1;
        4'b001?: nib_lz = 2'd2;
        default: nib_lz = 2'd3;
      endcase
    endfunction

    // Upward scan over groups: the highest non-zero nibble wins.
    always_comb begin
      grp_cnt = LZC_CNT_W'(Q);
      for (int g = 0; g < G; g++) begin
        if (|padded[4*g +: 4]) begin
          grp_cnt = LZC_CNT_W'((G - 1 - g) * 4)
                  + LZC_CNT_W'(nib_lz(padded[4*g +: 4]));
        end
      end
    end

    assign cnt_o = zero_o ? LZC_CNT_W'(WIDTH) : grp_cnt;

  end else begin : g_bad_arch
    $error("lzc_core: ARCH=%0d outside legal range 0..2", ARCH);
    assign cnt_o = '0;
  end

endmodule

// File: rtl/leading_zero_counter.sv
// ---------------------------------------------------------------------------
// leading_zero_counter
// Registered leading-zero counter, one-cycle latency, one word per cycle.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   i_valid, i_data   input word strobe and WIDTH-bit unsigned word
//   o_valid           lzc_cnt/o_zero carry a fresh result
//   lzc_cnt [6:0]     leading-zero count, 0..WIDTH (holds when idle)
//   o_zero            counted word was all zeros (holds when idle)
// ---------------------------------------------------------------------------
module leading_zero_counter
  import lzc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ARCH  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_data,
  output logic                 o_valid,
  output logic [LZC_CNT_W-1:0] lzc_cnt,
  output logic                 o_zero
);

  logic [LZC_CNT_W-1:0] cnt_d;
  logic                 zero_d;
  logic                 valid_q;
  logic [LZC_CNT_W-1:0] cnt_q;
  logic                 zero_q;

  lzc_core #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_core (
    .data_i (i_data),
    .cnt_o  (cnt_d),
    .zero_o (zero_d)
  );

  // Result registers only load on valid input so the last result holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= i_valid;
      if (i_valid) begin
        cnt_q  <= cnt_d;
        zero_q <= zero_d;
      end
    end
  end

  assign o_valid = valid_q;
  assign lzc_cnt = cnt_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_leading_zero_counter.sv
// ---------------------------------------------------------------------------
// tb_leading_zero_counter
// Runs all three architectures at WIDTH 1, 7, 26, 32, 33 and 64 in parallel
// on a shared input stream; each instance sees the low WIDTH bits.
// ---------------------------------------------------------------------------
module tb_leading_zero_counter;

  localparam int NW = 6;
  localparam int NA = 3;

  function automatic int wsel(input int idx);
    case (idx)
      0:       return 1;
      1:       return 7;
      2:       return 26;
      3:       return 32;
      4:       return 33;
      default: return 64;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stim_vld = 1'b0;
  logic [63:0] stim_data = '0;

  logic       ov  [NW][NA];
  logic [6:0] cnt [NW][NA];
  logic       zr  [NW][NA];

  always #5 clk = ~clk;

  for (genvar gw = 0; gw < NW; gw++) begin : g_w
    localparam int W = wsel(gw);
    for (genvar ga = 0; ga < NA; ga++) begin : g_a
      leading_zero_counter #(.WIDTH(W), .ARCH(ga)) u_dut (
        .clk     (clk),
        .reset   (rst),
        .i_valid (stim_vld),
        .i_data  (stim_data[W-1:0]),
        .o_valid (ov[gw][ga]),
        .lzc_cnt (cnt[gw][ga]),
        .o_zero  (zr[gw][ga])
      );
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference: zeros above the highest set bit among the low w bits.
  function automatic int ref_lz(input logic [63:0] d, input int w);
    int k;
    k = -1;
    for (int i = 0; i < w; i++) if (d[i]) k = i;
    return w - 1 - k;
  endfunction

  function automatic bit ref_zero(input logic [63:0] d, input int w);
    for (int i = 0; i < w; i++) if (d[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Expected registered outputs per width.
  bit m_valid [NW];
  int m_cnt   [NW];
  bit m_zero  [NW];

  always @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (rst) begin
        m_valid[w] <= 1'b0;
        m_cnt[w]   <= 0;
        m_zero[w]  <= 1'b0;
      end else begin
        m_valid[w] <= stim_vld;
        if (stim_vld) begin
          m_cnt[w]  <= ref_lz(stim_data, wsel(w));
          m_zero[w] <= ref_zero(stim_data, wsel(w));
        end
      end
    end
  end

  // Every-cycle comparison of all 18 instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int w = 0; w < NW; w++) begin
        for (int a = 0; a < NA; a++) begin
          n_cmp++;
          if (ov[w][a] !== m_valid[w] || cnt[w][a] !== 7'(m_cnt[w]) ||
              zr[w][a] !== m_zero[w]) begin
            n_fail++;
            if (n_fail <= 20)
              $display("FAIL model W=%0d ARCH=%0d t=%0t: got v=%0b cnt=%0d z=%0b, want v=%0b cnt=%0d z=%0b",
                       wsel(w), a, $time, ov[w][a], cnt[w][a], zr[w][a],
                       m_valid[w], m_cnt[w], m_zero[w]);
          end
        end
      end
    end
  end

  task automatic chk_model(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // Literal check of one width's three architectures.
  task automatic chk_lit(input string name, input int wi, input logic ev,
                         input int ec, input logic ez);
    for (int a = 0; a < NA; a++) begin
      n_cmp++;
      if (ov[wi][a] !== ev || cnt[wi][a] !== 7'(ec) || zr[wi][a] !== ez) begin
        n_fail++;
        $display("FAIL %s W=%0d ARCH=%0d: got v=%0b cnt=%0d z=%0b, want v=%0b cnt=%0d z=%0b",
                 name, wsel(wi), a, ov[wi][a], cnt[wi][a], zr[wi][a], ev, ec, ez);
      end
    end
  endtask

  task automatic send_check(input string name, input logic [63:0] word,
                            input int wi, input int ec, input logic ez);
    @(posedge clk); #1;
    stim_data = word;
    stim_vld  = 1'b1;
    @(posedge clk); #1;
    stim_vld  = 1'b0;
    chk_lit(name, wi, 1'b1, ec, ez);
    $display("txn %s: data=%h W=%0d expect cnt=%0d zero=%0b", name, word, wsel(wi), ec, ez);
  endtask

  initial begin
    logic [63:0] w64;
    logic [63:0] bitv;
    int          b;
    int          mode;

    // Pin the reference model with hand-computed values.
    chk_model("ref 1.0 Q16.16", ref_lz(64'h0000_0000_0001_0000, 32), 15);
    chk_model("ref zero W32", ref_lz(64'h0, 32), 32);
    chk_model("ref one W26", ref_lz(64'h1, 26), 25);
    chk_model("ref zero W1", ref_lz(64'h0, 1), 1);
    chk_model("ref msb W64", ref_lz(64'h8000_0000_0000_0000, 64), 0);
    chk_model("ref W7 ignores upper", ref_lz(64'hFF00, 7), 7);

    // Reset state.
    rst = 1'b1;
    stim_vld = 1'b1;
    stim_data = 64'hFFFF;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < NW; w++) chk_lit("reset", w, 1'b0, 0, 1'b0);
    rst = 1'b0;
    stim_vld = 1'b0;

    // Directed literal cases.
    send_check("q16_one", 64'h0000_0000_0001_0000, 3, 15, 1'b0);
    send_check("msb",     64'h0000_0000_8000_0000, 3, 0,  1'b0);
    send_check("lsb",     64'h0000_0000_0000_0001, 3, 31, 1'b0);
    send_check("ones",    64'h0000_0000_FFFF_FFFF, 3, 0,  1'b0);
    send_check("zero32",  64'h0,                   3, 32, 1'b1);
    send_check("zero26",  64'h0,                   2, 26, 1'b1);
    send_check("one26",   64'h1,                   2, 25, 1'b0);

    // Streaming 1<<31 down to 1<<0, then two idle cycles.
    for (int i = 0; i <= 32; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        chk_lit("stream", 3, 1'b1, i - 1, 1'b0);
        $display("txn stream: data=%h expect cnt=%0d", 64'h1 << (32 - i), i - 1);
      end
      if (i < 32) begin
        stim_data = 64'h1 << (31 - i);
        stim_vld  = 1'b1;
      end else begin
        stim_vld  = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_lit("idle_hold", 3, 1'b0, 31, 1'b0);
      $display("txn idle: expect valid=0 cnt=31 held");
    end

    // Reset dominating a valid input.
    @(posedge clk); #1;
    stim_data = 64'h10;
    stim_vld  = 1'b1;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    stim_vld  = 1'b0;
    for (int w = 0; w < NW; w++) chk_lit("reset_mid", w, 1'b0, 0, 1'b0);
    $display("txn reset_mid: data=10 discarded");
    @(posedge clk); #1;
    chk_lit("reset_lost", 3, 1'b0, 0, 1'b0);

    // Randomized equivalence, biased toward sparse words.
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #1;
      rst      = ($urandom_range(0, 299) == 0);
      stim_vld = ($urandom_range(0, 7) != 0);
      mode     = $urandom_range(0, 9);
      w64      = {$urandom, $urandom};
      if (mode < 2) begin
        stim_data = w64;
      end else if (mode < 6) begin
        b = $urandom_range(0, 63);
        bitv = 64'h1 << b;
        stim_data = bitv | (w64 & (bitv - 64'h1));
      end else if (mode < 8) begin
        b = $urandom_range(0, 7);
        bitv = 64'h1 << b;
        stim_data = ($urandom_range(0, 1) == 0) ? bitv : (bitv | (w64 & (bitv - 64'h1)));
      end else if (mode == 8) begin
        stim_data = 64'h1 << $urandom_range(0, 63);
      end else begin
        stim_data = 64'h0;
      end
      if (n < 8)
        $display("txn random %0d: data=%h valid=%0b reset=%0b", n, stim_data, stim_vld, rst);
    end
    @(posedge clk); #1;
    rst      = 1'b0;
    stim_vld = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
